array_output_fifo: RTL and testbench
====================================

# array_output_fifo

Parametrised multi-port output collector between the systolic array and the quantize/activate unit. Accepts up to NUM_PORTS results per cycle with row/column tags, compacts them in port-index order into a DEPTH-entry circular FIFO, and presents one result per cycle on a valid/consume read port. Adds what the 4-port, 4-deep buffer lacked: backpressure, occupancy and almost-full status, a flush, and a sticky overflow flag.

## Interface
- NUM_PORTS, 4, parallel write ports (1..8)
- DEPTH, 8, FIFO entries; power of two, DEPTH >= NUM_PORTS
- DATA_W, 32, result width (int32_t when 32)
- MAX_N, 16, max matrix dimension
- N_BITS, $clog2(MAX_N), row/col tag width
- AF_LEVEL, DEPTH-NUM_PORTS, almost_full threshold
- CNT_W, $clog2(DEPTH+1), occupancy width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  [NUM_PORTS] x 1  per-port write strobe
- in_output  in  [NUM_PORTS] x DATA_W  unquantized result
- in_row  in  [NUM_PORTS] x N_BITS  row tag
- in_col  in  [NUM_PORTS] x N_BITS  column tag
- in_ready  out  1  FIFO can take a full NUM_PORTS burst this cycle
- flush  in  1  synchronous clear of contents
- out_valid  out  1  head entry valid
- out_output  out  DATA_W  head result (0 when out_valid low)
- out_row  out  N_BITS  head row (0 when out_valid low)
- out_col  out  N_BITS  head col (0 when out_valid low)
- out_consume  in  1  pop head
- count  out  CNT_W  registered occupancy
- almost_full  out  1  count >= AF_LEVEL
- overflow_err  out  1  sticky: a write was dropped

## Operation
- Reset (async assert): wr_ptr=rd_ptr=0, count=0, overflow_err=0. Outputs: in_ready=1, out_valid=0, out_output/row/col=0, count=0, almost_full=(AF_LEVEL==0). Storage array not reset.
- in_ready = (DEPTH - count) >= NUM_PORTS, from registered count only; a same-cycle pop does not raise it.
- Write acceptance is all-or-nothing per cycle: when in_ready=1, every port with in_valid=1 is written; port i goes to wr_ptr + (number of valid ports j<i), mod DEPTH. wr_ptr advances by the popcount of in_valid.
- in_valid on any port while in_ready=0: whole cycle's writes dropped, pointers unchanged, overflow_err set next edge.
- Read: pop = out_consume && out_valid; rd_ptr += 1 mod DEPTH. out_consume while empty is ignored, with no error.
- count_next = count + accepted_writes - pop; never exceeds DEPTH or underflows by construction.
- flush has priority: next state is empty with pointers 0; same-cycle writes and pop are discarded; overflow_err cleared. Dropped writes in a flush cycle do not set overflow_err.
- overflow_err is cleared only by reset or flush.
- Pointer arithmetic is modulo DEPTH (natural wrap of $clog2(DEPTH) bits). count is kept separately so full and empty are distinguishable.

## Timing
- Write-to-read latency 1: data written at edge k is visible on out_* after edge k when the FIFO was empty.
- out_* are combinational from registered rd_ptr/count/storage and are stable for the whole cycle.
- Pop takes effect at the edge; the next entry is presented in the following cycle, giving one pop per cycle sustained.
- Simultaneous write and pop in one cycle are both applied. When count was 0, the pop is not possible (out_valid=0).
- Reset deassertion mid-burst: the first edge after release accepts writes normally. Writes asserted during reset are lost silently, and overflow_err is not set.
- in_ready, almost_full and count all change only at clock edges.

## Structure
- sys_types package: int32_t (already present). Add the array_out_entry_t helper only if DATA_W/N_BITS are fixed; otherwise keep a local packed entry struct {data, row, col}.
- Sub-module valid_prefix_count #(NUM_PORTS): combinational exclusive prefix popcount of in_valid → per-port offset plus total. It is reused by the future input-side gatherer.
- Top: storage array, pointers, count, flag registers, output gating.

## Test plan
- Reset then a single write on port 2 (data 0x11, row 3, col 5): next cycle out_valid=1, out_output=0x11, row 3, col 5, count=1, other outputs 0 before the write.
- NUM_PORTS=4, DEPTH=8: in_valid=1011 with data A,B,D on ports 0,1,3 → entries read out in order A,B,D; count 3 then drains to 0.
- Two full bursts (8 entries) with no consume → in_ready=0, almost_full=1. A third burst is dropped: overflow_err=1, count stays 8, and the readout shows only the first 8 in order.
- Continuous 1-port writes plus consume every cycle for 40 cycles → pointer wrap, count constant at 1, data order preserved, overflow_err=0.
- count=5 with flush asserted together with a 4-port write and consume → next cycle count=0, out_valid=0, overflow_err=0, in_ready=1.
- Assert reset asynchronously mid-burst (between edges): outputs go to reset values immediately; after release, a 4-port write is accepted normally.

Source files
------------

// File: rtl/array_output_fifo_pkg.sv
// Shared types, default sizes and pointer helpers for the systolic-array output collector.
package array_output_fifo_pkg;

  typedef logic signed [31:0] int32_t;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_N     = 16;

  // A one-entry FIFO still needs a 1-bit pointer; its mask then pins the index at 0.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/array_output_fifo_if.sv
// Write/read/status bundle between the systolic array, the output FIFO and the quantize/activate unit.
interface array_output_fifo_if
  import array_output_fifo_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int N_BITS    = $clog2(DEF_MAX_N),
  parameter int CNT_W     = $clog2(DEF_DEPTH + 1)
);

  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] in_output;
  logic [NUM_PORTS-1:0][N_BITS-1:0] in_row;
  logic [NUM_PORTS-1:0][N_BITS-1:0] in_col;
  logic                             in_ready;
  logic                             flush;
  logic                             out_valid;
  logic [DATA_W-1:0]                out_output;
  logic [N_BITS-1:0]                out_row;
  logic [N_BITS-1:0]                out_col;
  logic                             out_consume;
  logic [CNT_W-1:0]                 count;
  logic                             almost_full;
  logic                             overflow_err;

  modport master (
    output in_valid, in_output, in_row, in_col, flush, out_consume,
    input  in_ready, out_valid, out_output, out_row, out_col, count, almost_full, overflow_err
  );

  modport slave (
    input  in_valid, in_output, in_row, in_col, flush, out_consume,
    output in_ready, out_valid, out_output, out_row, out_col, count, almost_full, overflow_err
  );

endinterface

// File: rtl/array_output_fifo_valid_prefix_count.sv
// Exclusive prefix popcount of a valid vector: per-port compaction offset plus total.
module valid_prefix_count #(
  parameter int NUM_PORTS = 4,
  parameter int OFF_W     = $clog2(NUM_PORTS + 1)
) (
  input  logic [NUM_PORTS-1:0]            valid,
  output logic [NUM_PORTS-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]                total
);

  logic [OFF_W-1:0] acc;

  // NOTE: every variable is given a value before any branch or loop, so no latch is inferred.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      offset[i] = acc;
      acc       = acc + OFF_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/array_output_fifo.sv
// Multi-port result collector: compacts up to NUM_PORTS tagged results per cycle into a circular FIFO.
module array_output_fifo
  import array_output_fifo_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_N     = DEF_MAX_N,
  parameter int N_BITS    = $clog2(MAX_N),
  parameter int AF_LEVEL  = DEPTH - NUM_PORTS,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                reset,
  array_output_fifo_if.slave bus
);

  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam int               OFF_W    = $clog2(NUM_PORTS + 1);
  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [N_BITS-1:0] row;
    logic [N_BITS-1:0] col;
  } entry_t;

  entry_t                          mem_q [DEPTH];
  entry_t                          mem_d [DEPTH];
  entry_t                          head;
  logic   [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic   [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic   [PTR_W-1:0]              slot;
  logic   [CNT_W-1:0]              count_q, count_d;
  logic   [CNT_W-1:0]              n_accepted;
  logic                            overflow_q, overflow_d;
  logic   [NUM_PORTS-1:0][OFF_W-1:0] offset;
  logic   [OFF_W-1:0]              total;
  logic                            in_ready, out_valid, any_valid;
  logic                            accept, drop, pop;

  valid_prefix_count #(
    .NUM_PORTS(NUM_PORTS),
    .OFF_W    (OFF_W)
  ) u_prefix (
    .valid (bus.in_valid),
    .offset(offset),
    .total (total)
  );

  // Room is judged on the registered count only, so a pop this cycle never opens the gate early.
  assign in_ready   = (count_q <= CNT_W'(DEPTH - NUM_PORTS));
  assign out_valid  = (count_q != '0);
  assign any_valid  = |bus.in_valid;
  assign accept     = in_ready && !bus.flush;
  assign drop       = any_valid && !in_ready && !bus.flush;
  assign pop        = bus.out_consume && out_valid && !bus.flush;
  assign n_accepted = accept ? CNT_W'(total) : '0;

  always_comb begin
    mem_d = mem_q;
    slot  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      slot = (wr_ptr_q + PTR_W'(offset[i])) & PTR_MASK;
      if (accept && bus.in_valid[i]) begin
        mem_d[slot] = '{data: bus.in_output[i], row: bus.in_row[i], col: bus.in_col[i]};
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read, so stale words never leak.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = (wr_ptr_q + PTR_W'(total)) & PTR_MASK;
      if (pop)    rd_ptr_d = (rd_ptr_q + PTR_W'(1)) & PTR_MASK;
      count_d = count_q + n_accepted - CNT_W'(pop);
      if (drop) overflow_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_output   = out_valid ? head.data : '0;
  assign bus.out_row      = out_valid ? head.row  : '0;
  assign bus.out_col      = out_valid ? head.col  : '0;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_array_output_fifo.sv
// Directed self-checking bench for array_output_fifo at NUM_PORTS=4, DEPTH=8.
module tb_array_output_fifo;
  import array_output_fifo_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  array_output_fifo_if #(.NUM_PORTS(NP), .DATA_W(DW), .N_BITS(NB), .CNT_W(CW)) bus ();

  array_output_fifo dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = '0;
    bus.in_output   = '0;
    bus.in_row      = '0;
    bus.in_col      = '0;
    bus.flush       = 1'b0;
    bus.out_consume = 1'b0;
  endtask

  task automatic put(input int port, input logic [31:0] d, input logic [3:0] r, input logic [3:0] c);
    bus.in_valid[port]  = 1'b1;
    bus.in_output[port] = d;
    bus.in_row[port]    = r;
    bus.in_col[port]    = c;
  endtask

  task automatic burst4(input logic [31:0] base);
    for (int i = 0; i < NP; i++) put(i, base + 32'(i), 4'(i), 4'(i + 1));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp_data, input int exp_count);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, 64'(bus.out_output), 64'(exp_data));
    bus.out_consume = 1'b1;
    tick();
    bus.out_consume = 1'b0;
    check({tag, "_count"}, 64'(bus.count), 64'(exp_count));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_output"}, 64'(bus.out_output), 64'd0);
    check({tag, "_out_row"}, 64'(bus.out_row), 64'd0);
    check({tag, "_out_col"}, 64'(bus.out_col), 64'd0);
    check({tag, "_count"}, 64'(bus.count), 64'd0);
    check({tag, "_almost_full"}, 64'(bus.almost_full), 64'd0);
    check({tag, "_overflow"}, 64'(bus.overflow_err), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    #2 reset = 1'b0;

    // Single write on port 2, visible one edge later.
    put(2, 32'h11, 4'd3, 4'd5);
    tick();
    idle();
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_data", 64'(bus.out_output), 64'h11);
    check("single_row", 64'(bus.out_row), 64'd3);
    check("single_col", 64'(bus.out_col), 64'd5);
    check("single_count", 64'(bus.count), 64'd1);
    pop_check("single_pop", 32'h11, 0);

    // Consume on an empty FIFO is ignored without error.
    bus.out_consume = 1'b1;
    tick();
    idle();
    check("empty_pop_count", 64'(bus.count), 64'd0);
    check("empty_pop_overflow", 64'(bus.overflow_err), 64'd0);

    // Sparse valid 1011 compacts in port order.
    put(0, 32'hA, 4'd1, 4'd1);
    put(1, 32'hB, 4'd2, 4'd2);
    put(3, 32'hD, 4'd4, 4'd4);
    tick();
    idle();
    check("sparse_count", 64'(bus.count), 64'd3);
    pop_check("sparse_a", 32'hA, 2);
    pop_check("sparse_b", 32'hB, 1);
    pop_check("sparse_d", 32'hD, 0);

    // Fill to DEPTH, then a dropped third burst.
    burst4(32'h100);
    tick();
    idle();
    check("fill1_count", 64'(bus.count), 64'd4);
    check("fill1_in_ready", 64'(bus.in_ready), 64'd1);
    check("fill1_almost_full", 64'(bus.almost_full), 64'd1);
    burst4(32'h104);
    tick();
    idle();
    check("fill2_count", 64'(bus.count), 64'd8);
    check("fill2_in_ready", 64'(bus.in_ready), 64'd0);
    check("fill2_overflow", 64'(bus.overflow_err), 64'd0);
    burst4(32'h108);
    tick();
    idle();
    check("drop_overflow", 64'(bus.overflow_err), 64'd1);
    check("drop_count", 64'(bus.count), 64'd8);
    for (int i = 0; i < 8; i++) pop_check("full_drain", 32'h100 + 32'(i), 7 - i);
    check("sticky_overflow", 64'(bus.overflow_err), 64'd1);
    bus.flush = 1'b1;
    tick();
    idle();
    check("flush_clears_overflow", 64'(bus.overflow_err), 64'd0);

    // Streaming one write plus one pop per cycle across pointer wrap.
    put(1, 32'h200, 4'd0, 4'd0);
    tick();
    idle();
    for (int i = 0; i < 40; i++) begin
      check("stream_head", 64'(bus.out_output), 64'(32'h200 + 32'(i)));
      put(i % NP, 32'h201 + 32'(i), 4'(i), 4'(i + 2));
      bus.out_consume = 1'b1;
      tick();
      idle();
      check("stream_count", 64'(bus.count), 64'd1);
    end
    check("stream_overflow", 64'(bus.overflow_err), 64'd0);
    pop_check("stream_last", 32'h228, 0);

    // Flush beats a same-cycle write and pop, and a dropped write in that cycle is not flagged.
    burst4(32'h300);
    tick();
    idle();
    put(0, 32'h304, 4'd0, 4'd0);
    tick();
    idle();
    check("pre_flush_count", 64'(bus.count), 64'd5);
    check("pre_flush_in_ready", 64'(bus.in_ready), 64'd0);
    burst4(32'h310);
    tick();
    idle();
    check("pre_flush_overflow", 64'(bus.overflow_err), 64'd1);
    check("pre_flush_count_held", 64'(bus.count), 64'd5);
    bus.flush = 1'b1;
    burst4(32'h320);
    bus.out_consume = 1'b1;
    tick();
    idle();
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_overflow", 64'(bus.overflow_err), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset between edges, writes held through it are lost.
    burst4(32'h400);
    tick();
    burst4(32'h410);
    check("pre_reset_count", 64'(bus.count), 64'd4);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    check("reset_write_count", 64'(bus.count), 64'd0);
    check("reset_write_overflow", 64'(bus.overflow_err), 64'd0);
    reset = 1'b0;
    idle();
    burst4(32'h420);
    tick();
    idle();
    check("post_reset_count", 64'(bus.count), 64'd4);
    check("post_reset_row", 64'(bus.out_row), 64'd0);
    check("post_reset_col", 64'(bus.out_col), 64'd1);
    for (int i = 0; i < 4; i++) pop_check("post_reset_drain", 32'h420 + 32'(i), 3 - i);
    check("post_reset_overflow", 64'(bus.overflow_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
